// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_24110015_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Combinational byte-lane logic: store lane placement and mask, load
// extraction with sign/zero extension, and the misaligned-access flag.
module ysyx_24110015_lsu_align
  import ysyx_24110015_lsu_pkg::*;
(
  input  logic [1:0]  addr_off,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rdata_shift;

  assign rdata_shift = rdata_in >> {addr_off, 3'b000};

  // Undefined size encodings are reported as misaligned so they never reach memory.
  always_comb begin
    misaligned = 1'b1;
    case (func3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = addr_off[0];
      F3_W:        misaligned = (addr_off != 2'b00);
      default:     misaligned = 1'b1;
    endcase
  end

  // Store data is moved into the addressed byte lane together with its byte enables.
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = 32'h0;
    case (func3)
      F3_B: begin
        wmask      = 4'b0001 << addr_off;
        wdata_lane = wdata_in << {addr_off, 3'b000};
      end
      F3_H: begin
        wmask      = 4'b0011 << addr_off;
        wdata_lane = wdata_in << {addr_off, 3'b000};
      end
      F3_W: begin
        wmask      = 4'b1111;
        wdata_lane = wdata_in;
      end
      default: begin
        wmask      = 4'b0000;
        wdata_lane = 32'h0;
      end
    endcase
  end

  // Load data is shifted down from its lane and extended to a full word.
  always_comb begin
    rdata_ext = 32'h0;
    case (func3)
      F3_B:    rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      F3_H:    rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      F3_W:    rdata_ext = rdata_shift;
      F3_BU:   rdata_ext = {24'h0, rdata_shift[7:0]};
      F3_HU:   rdata_ext = {16'h0, rdata_shift[15:0]};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: takes one EXU instruction at a time, issues a handshaked
// memory request when needed, and hands the result to write-back.
module ysyx_24110015_lsu
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_func3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  // Last counter value before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       func3_q;
  logic             store_q;

  logic [1:0]       align_off;
  logic [2:0]       align_f3;
  logic [3:0]       st_wmask;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;
  logic             misaligned;

  assign in_ready = (state == IDLE);

  // While idle the aligner looks at the incoming instruction; afterwards at the latched one.
  assign align_off = (state == IDLE) ? in_addr[1:0] : off_q;
  assign align_f3  = (state == IDLE) ? in_func3 : func3_q;

  ysyx_24110015_lsu_align u_align (
    .addr_off   (align_off),
    .func3      (align_f3),
    .wdata_in   (in_wdata),
    .rdata_in   (mem_rdata),
    .wmask      (st_wmask),
    .wdata_lane (st_wdata),
    .rdata_ext  (ld_data),
    .misaligned (misaligned)
  );

  // Transaction sequencer with all handshake and result outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      off_q         <= 2'b00;
      func3_q       <= 3'b000;
      store_q       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 4'b0000;
      out_valid     <= 1'b0;
      out_data      <= 32'h0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            off_q    <= in_addr[1:0];
            func3_q  <= in_func3;
            store_q  <= in_mem_write;
            mem_addr <= {in_addr[31:2], 2'b00};
            cnt      <= '0;
            if (!in_mem_read && !in_mem_write) begin
              out_data  <= in_addr;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (misaligned) begin
              out_data  <= 32'h0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mem_wen       <= in_mem_write;
              mem_wmask     <= in_mem_write ? st_wmask : 4'b0000;
              mem_wdata     <= in_mem_write ? st_wdata : 32'h0;
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            out_data  <= store_q ? 32'h0 : ld_data;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            out_data  <= 32'h0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Bench for the load/store unit: directed and randomized transactions
// compared against a byte-lane reference model, plus the aligner alone.
module tb_ysyx_24110015_lsu;
  import ysyx_24110015_lsu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic [2:0]  in_func3 = 3'b000;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  logic [1:0]  a_off = 2'b00;
  logic [2:0]  a_f3 = 3'b000;
  logic [31:0] a_wd = 32'h0;
  logic [31:0] a_rd = 32'h0;
  logic [3:0]  a_wmask;
  logic [31:0] a_wlane;
  logic [31:0] a_rext;
  logic        a_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24110015_lsu #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_func3       (in_func3),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err        (out_err)
  );

  ysyx_24110015_lsu_align u_align_alone (
    .addr_off   (a_off),
    .func3      (a_f3),
    .wdata_in   (a_wd),
    .rdata_in   (a_rd),
    .wmask      (a_wmask),
    .wdata_lane (a_wlane),
    .rdata_ext  (a_rext),
    .misaligned (a_mis)
  );

  // Access size in bytes implied by func3; 0 marks an undefined encoding.
  function automatic int sizeOf(logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit expMisaligned(logic [2:0] f3, int o);
    int size = sizeOf(f3);
    if (size == 0) return 1'b1;
    return (o % size) != 0;
  endfunction

  function automatic logic [3:0] expMask(logic [2:0] f3, int o);
    int m = ((1 << sizeOf(f3)) - 1) << o;
    return m[3:0];
  endfunction

  function automatic logic [31:0] expWdata(logic [31:0] wd, int o);
    longint v = {32'h0, wd} << (8 * o);
    return v[31:0];
  endfunction

  function automatic logic [31:0] expLoad(logic [31:0] word, logic [2:0] f3, int o);
    int     size = sizeOf(f3);
    longint full = longint'(1) << (8 * size);
    longint v    = ({32'h0, word} >> (8 * o)) % full;
    if ((f3 == F3_B || f3 == F3_H) && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction from IDLE back to IDLE; the DUT must be idle on entry.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd,
                               input logic [2:0] f3, input bit rd, input bit wr,
                               input int reqStall, input int respDelay, input bit noResp,
                               input logic [31:0] rdata, input int outStall);
    bit          isMem = rd || wr;
    int          o     = int'(addr[1:0]);
    bit          mis   = isMem && expMisaligned(f3, o);
    logic [31:0] expData;
    logic        expErr;

    checkOutput("in_ready idle", in_ready, 1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_func3 = f3;
    in_mem_read = rd; in_mem_write = wr;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;

    if (!isMem || mis) begin
      checkOutput("no mem req", mem_req_valid, 0);
      expData = isMem ? 32'h0 : addr;
      expErr  = mis;
    end else begin
      for (int i = 0; i <= reqStall; i++) begin
        checkOutput("req valid", mem_req_valid, 1);
        checkOutput("req addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("req wen", mem_wen, wr);
        checkOutput("req wmask", mem_wmask, wr ? expMask(f3, o) : 4'b0000);
        if (wr) checkOutput("req wdata", mem_wdata, expWdata(wd, o));
        if (i < reqStall) begin
          @(posedge clk); #1;
        end
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      checkOutput("req dropped", mem_req_valid, 0);
      checkOutput("wait no out", out_valid, 0);
      if (noResp) begin
        for (int i = 1; i < TO; i++) begin
          @(posedge clk); #1;
          checkOutput("pre-timeout", out_valid, 0);
        end
        @(posedge clk); #1;
        expData = 32'h0;
        expErr  = 1'b1;
      end else begin
        for (int i = 1; i < respDelay; i++) begin
          mem_rdata = $urandom;
          @(posedge clk); #1;
          checkOutput("resp pending", out_valid, 0);
        end
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_rdata = $urandom;
        expData = wr ? 32'h0 : expLoad(rdata, f3, o);
        expErr  = 1'b0;
      end
    end

    for (int i = 0; i <= outStall; i++) begin
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, expData);
      checkOutput("out_err", out_err, expErr);
      checkOutput("no bypass", in_ready, 0);
      if (i < outStall) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out released", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] stF3[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    // Reset state
    #12;
    checkOutput("rst mem_req_valid", mem_req_valid, 0);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_data", out_data, 0);
    checkOutput("rst out_err", out_err, 0);
    checkOutput("rst mem_wen", mem_wen, 0);
    checkOutput("rst mem_wmask", mem_wmask, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst in_ready", in_ready, 1);

    // Directed scenarios
    applyStimulus(32'h8000_0010, 32'h0, F3_W, 1, 0, 0, 3, 0, 32'hDEAD_BEEF, 0);
    applyStimulus(32'h8000_0003, 32'h0, F3_B, 1, 0, 1, 1, 0, 32'h80FF_7F01, 0);
    applyStimulus(32'h8000_0003, 32'h0, F3_BU, 1, 0, 0, 2, 0, 32'h80FF_7F01, 0);
    applyStimulus(32'h8000_0002, 32'h1234_ABCD, F3_H, 0, 1, 4, 1, 0, 32'h0, 0);
    applyStimulus(32'h0000_0055, 32'h0, F3_W, 0, 0, 0, 1, 0, 32'h0, 2);
    applyStimulus(32'h8000_0002, 32'h0, F3_W, 1, 0, 0, 1, 0, 32'h0, 0);
    applyStimulus(32'h8000_0020, 32'h0, F3_W, 1, 0, 0, 1, 1, 32'h0, 1);
    applyStimulus(32'h8000_0006, 32'h0, F3_HU, 1, 0, 0, 1, 0, 32'h8765_4321, 0);
    applyStimulus(32'h8000_0004, 32'hCAFE_F00D, F3_W, 1, 1, 0, 2, 0, 32'h1111_1111, 0);
    applyStimulus(32'h8000_0000, 32'h0, 3'b011, 1, 0, 0, 1, 0, 32'h0, 0);

    // Reset pulsed while waiting for a response; the late response must be ignored
    in_valid = 1'b1; in_addr = 32'h8000_0040; in_func3 = F3_W;
    in_mem_read = 1'b1; in_mem_write = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("wait-rst req", mem_req_valid, 0);
    checkOutput("wait-rst out", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("wait-rst in_ready", in_ready, 1);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    checkOutput("late resp out", out_valid, 0);
    checkOutput("late resp req", mem_req_valid, 0);

    // Reset pulsed while the request is outstanding
    in_valid = 1'b1; in_addr = 32'h8000_0044;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("req before rst", mem_req_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("req-rst req", mem_req_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset pulsed while a result is waiting for write-back
    in_valid = 1'b1; in_addr = 32'h0000_0077; in_mem_read = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("done before rst", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("done-rst out", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("done-rst in_ready", in_ready, 1);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      int          kind = $urandom_range(0, 3);
      logic [31:0] addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      logic [2:0]  f3;
      bit          rd = 0;
      bit          wr = 0;
      case (kind)
        0: begin rd = 1; f3 = 3'($urandom_range(0, 7)); end
        1: begin wr = 1; f3 = stF3[$urandom_range(0, 5)]; end
        2: begin rd = 1; wr = 1; f3 = stF3[$urandom_range(0, 5)]; end
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      applyStimulus(addr, $urandom, f3, rd, wr, $urandom_range(0, 3),
                    $urandom_range(1, TO - 2), 0, $urandom, $urandom_range(0, 2));
    end

    // Aligner on its own
    for (int n = 0; n < 200; n++) begin
      a_off = 2'($urandom_range(0, 3));
      a_f3  = 3'($urandom_range(0, 7));
      a_wd  = $urandom;
      a_rd  = $urandom;
      #1;
      checkOutput("align misaligned", a_mis, expMisaligned(a_f3, int'(a_off)));
      if (!expMisaligned(a_f3, int'(a_off))) begin
        checkOutput("align load", a_rext, expLoad(a_rd, a_f3, int'(a_off)));
        if (a_f3 == F3_B || a_f3 == F3_H || a_f3 == F3_W) begin
          checkOutput("align wmask", a_wmask, expMask(a_f3, int'(a_off)));
          checkOutput("align wdata", a_wlane, expWdata(a_wd, int'(a_off)));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_lsu.md
Name: ysyx_24110015_lsu

Overview:
- Load/store unit directly downstream of the execute stage. It replaces direct DPI memory calls with a handshaked memory port.
- Accepts one instruction per transaction from EXU (address = ALU result, store data = rs2, func3, read/write flags) and performs byte-lane alignment, write masking, load extension and a response timeout.
- Passes non-memory results through to the write-back stage.

Parameters:
TIMEOUT, 256, max cycles waiting for mem_resp_valid before the error path; 0 disables the timeout.
CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  EXU presents an instruction
in_ready  out  1  LSU can accept (high only in IDLE)
in_addr  in  32  ALU result: memory address, or pass-through data
in_wdata  in  32  store data (rs2)
in_func3  in  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
in_mem_read  in  1  load
in_mem_write  in  1  store
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address {in_addr[31:2],2'b00}
mem_wen  out  1  1 = write
mem_wdata  out  32  store data shifted to its lane
mem_wmask  out  4  byte-enable
mem_resp_valid  in  1  memory response / write ack
mem_rdata  in  32  read data (full word)
out_valid  out  1  result for WBU
out_ready  in  1  WBU accepts
out_data  out  32  load result, pass-through value, or 0 for stores and errors
out_err  out  1  misaligned access or timeout; qualified by out_valid

Behaviour:
- The stated clock/reset fact is fixed: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state=IDLE, mem_req_valid=0, out_valid=0, out_data=0, out_err=0, counter=0, mem_wen=0, mem_wmask=0. in_ready=1 after reset deasserts.
- State machine: IDLE, REQ, WAIT, DONE.
  - IDLE: accept on in_valid&&in_ready. Inputs are latched.
    - Neither read nor write -> DONE, out_data=in_addr (1-cycle latency).
    - Misaligned -> DONE, out_err=1, out_data=0, no memory request.
    - Otherwise -> REQ.
  - REQ: mem_req_valid=1. Address, data and mask are held stable until mem_req_ready.
    - On mem_req_valid&&mem_req_ready -> WAIT.
    - A response in the same cycle as the request handshake is not legal; memory responds at the earliest the next cycle.
  - WAIT: counter increments each cycle.
    - On mem_resp_valid -> DONE with the formatted data.
    - If TIMEOUT>0 and counter reaches TIMEOUT -> DONE, out_err=1, out_data=0.
    - A late response after the timeout is ignored.
  - DONE: out_valid=1. Data is held until out_ready, then -> IDLE and the counter is cleared.
    - The next in_valid is accepted the cycle after, never in the same cycle (no bypass).
- Misaligned definition: halfword with addr[0]=1, or word with addr[1:0]!=0. Undefined func3 (011,110,111) is treated as misaligned.
- Store lanes, with o=addr[1:0]:
  - sb: wmask=0001<<o, wdata=in_wdata<<(8*o).
  - sh: wmask=0011<<o.
  - sw: wmask=1111.
- Load formatting: r = mem_rdata>>(8*o).
  - lb: sign-extend r[7:0].
  - lh: sign-extend r[15:0].
  - lw: r unchanged.
  - lbu/lhu: zero-extend.
- Loads drive wmask=0000 and wen=0.
- Store responses (write ack) produce out_data=0.
- in_mem_read and in_mem_write both set: the store wins, and a read is not performed.
- Reset asserted mid-transaction: immediate return to IDLE. The outstanding request is abandoned, and out_valid and mem_req_valid drop asynchronously.

Decomposition:
- Shared package:
  - lsu_state_e enum: IDLE, REQ, WAIT, DONE.
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One sub-module: ysyx_24110015_lsu_align. It is combinational and produces the store wmask/wdata, the load extract/extend, and the misaligned flag. Test it standalone.

Test Plan:
- lw at 0x80000010, memory returns 0xDEADBEEF after a 3-cycle delay -> mem_addr=0x80000010, wmask=0000; out_data=0xDEADBEEF, out_err=0.
- lb at 0x80000003, mem_rdata=0x80FF7F01 -> out_data=0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh at 0x80000002, rs2=0x1234ABCD, mem_req_ready held low for 4 cycles -> request stable throughout; wmask=1100, mem_wdata=0xABCD0000, wen=1; after the ack, out_data=0.
- Pass-through, no mem flags, in_addr=0x55 -> out_valid the next cycle with 0x55; no mem_req_valid. With out_ready low for 2 cycles, the output is held.
- lw at 0x80000002 -> no memory request, out_err=1. TIMEOUT=8 with no response -> out_err=1 exactly 8 cycles after entering WAIT.
- rst pulsed during WAIT -> mem_req_valid=0, out_valid=0, state IDLE, in_ready=1 after release; a late mem_resp_valid is ignored.
